// File: rtl/seven_seg_capture.sv
// Receiver for a multiplexed active-low seven-segment display bus: filters scan
// transitions, decodes settled segment patterns back to BCD and holds four digits.
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        update,
    output logic        bad_pattern,
    output logic        frame_done
);

    typedef enum logic [1:0] {StChanging, StSettling, StHeld} state_e;

    localparam logic [15:0] StableCnt = 16'(STABLE_CYCLES);

    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    state_e      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  mask_q;

    logic        same;
    logic        accept;
    logic        an_onehot;
    logic [1:0]  idx;
    logic        seg_hit;
    logic [3:0]  seg_val;
    logic        seg_blank;
    logic [3:0]  mask_set;

    always_comb begin
        same      = ({an_in, seg_in} == {an_q, seg_q});
        // cnt_q counts identical samples already held; the accept fires on the
        // edge after the STABLE_CYCLES-th one.
        accept    = (state_q != StHeld) && (cnt_q == StableCnt);
        an_onehot = 1'b1;
        idx       = 2'd0;
        unique case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: an_onehot = 1'b0;
        endcase
        seg_hit = 1'b1;
        seg_val = 4'd0;
        case (seg_q)
            7'b1000000: seg_val = 4'd0;
            7'b1111001: seg_val = 4'd1;
            7'b0100100: seg_val = 4'd2;
            7'b0110000: seg_val = 4'd3;
            7'b0011001: seg_val = 4'd4;
            7'b0010010: seg_val = 4'd5;
            7'b0000010: seg_val = 4'd6;
            7'b1111000: seg_val = 4'd7;
            7'b0000000: seg_val = 4'd8;
            7'b0010000: seg_val = 4'd9;
            default:    seg_hit = 1'b0;
        endcase
        seg_blank = (seg_q == 7'b1111111);
        mask_set  = mask_q | (4'(1) << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q        <= 4'hF;
            seg_q       <= 7'h7F;
            state_q     <= StChanging;
            cnt_q       <= 16'd0;
            mask_q      <= 4'd0;
            digits      <= 16'hFFFF;
            digit_valid <= 4'd0;
            update      <= 1'b0;
            bad_pattern <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            an_q        <= an_in;
            seg_q       <= seg_in;
            update      <= 1'b0;
            bad_pattern <= 1'b0;
            frame_done  <= 1'b0;

            if (!same) begin
                state_q <= StChanging;
                cnt_q   <= 16'd1;
            end else if (accept) begin
                state_q <= StHeld;
            end else if (state_q != StHeld) begin
                state_q <= StSettling;
                cnt_q   <= cnt_q + 16'd1;
            end

            if (accept && an_q != 4'hF) begin
                if (!an_onehot) begin
                    bad_pattern <= 1'b1;
                end else begin
                    update <= 1'b1;
                    if (seg_hit) begin
                        digits[int'(idx)*4 +: 4] <= seg_val;
                        digit_valid[idx]         <= 1'b1;
                    end else if (seg_blank) begin
                        digits[int'(idx)*4 +: 4] <= 4'hF;
                        digit_valid[idx]         <= 1'b0;
                    end else begin
                        digit_valid[idx] <= 1'b0;
                        bad_pattern      <= 1'b1;
                    end
                    if (mask_set == 4'hF) begin
                        frame_done <= 1'b1;
                        mask_q     <= 4'd0;
                    end else begin
                        mask_q <= mask_set;
                    end
                end
            end
        end
    end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receiving end of the multiplexed seven-segment display interface. Samples the active-low anode-select and segment lines driven by a display driver, filters out scan transitions, decodes each settled segment pattern back to a BCD digit, and holds the four reconstructed digits in registers. It is used for on-board loopback checks of the display path and as a self-checking monitor in system benches.

## Interface
- STABLE_CYCLES, default 1000: consecutive identical registered samples of {an_in, seg_in} required before a sample is accepted. Legal range 1..65535; the settle counter is 16 bits.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- an_in  input  4  anode selects, active-low. Bit i low selects digit i.
- seg_in  input  7  segments, active-low. Bit 0 = a through bit 6 = g.
- digits  output  16  digit i at [4i+3:4i]; 4'hF means blank or unknown.
- digit_valid  output  4  bit i set when digit i holds a decoded 0..9.
- update  output  1  one-cycle pulse on any write to digits or digit_valid.
- bad_pattern  output  1  one-cycle pulse when an accepted sample is illegal.
- frame_done  output  1  one-cycle pulse when all four digits have been written since the last frame_done or reset.

## Operation
- Input stage: an_in and seg_in are registered once into sample registers.
- Settle FSM with 16-bit counter cnt:
  - CHANGING: entered when the new registered sample differs from the previous one; cnt <= 1.
  - SETTLING: sample unchanged; cnt increments. The accept action fires on the cycle cnt reaches STABLE_CYCLES, then the FSM moves to HELD.
  - HELD: sample unchanged; no further action.
  - Any change in the sample returns the FSM to CHANGING from any state.
- Accept action, decided on an:
  - 4'b1111: blanking. No write and no pulse.
  - Exactly one bit low (1110, 1101, 1011, 0111): index i. Decode seg per the segment table below.
  - Any other an value: pulse bad_pattern. No write, and the frame mask is unchanged.
- Segment table, as {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Segment decode result:
  - Table hit: digits[i] <= value, digit_valid[i] <= 1, update pulses.
  - 7'b1111111: digits[i] <= 4'hF, digit_valid[i] <= 0, update pulses.
  - Other pattern: digit_valid[i] <= 0, digits[i] unchanged, update and bad_pattern both pulse.
- Frame mask: 4 bits. Bit i is set on every accept at index i, including blank or bad segment patterns.
  - When the mask would become 4'b1111, frame_done pulses in the same cycle as update and the mask clears.
  - Rewriting an index already set in the mask leaves the mask unchanged.

## Timing
- Reset values:
  - digits = 16'hFFFF, digit_valid = 4'b0000, update = bad_pattern = frame_done = 0.
  - Frame mask cleared, FSM in CHANGING with cnt = 0.
  - Sample registers loaded with all-ones.
- Reset mid-SETTLING: no accept fires; the sample must settle again for the full STABLE_CYCLES after reset.
- Latency:
  - A value first registered at edge E and unchanged through edge E+STABLE_CYCLES-1 is accepted.
  - Its outputs are visible after edge E+STABLE_CYCLES.
  - With STABLE_CYCLES=1, outputs are visible after edge E+1.
- Each settled value produces at most one accept, however long it is held.
- Pulse outputs are high for exactly one cycle per accept.
- A value held for fewer than STABLE_CYCLES samples is discarded silently.
- No handshake and no backpressure. Scan rates faster than STABLE_CYCLES per digit produce no updates.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset: rst high for 2 cycles with arbitrary inputs -> digits=16'hFFFF, digit_valid=0, no pulses for 10 cycles with an_in=4'hF.
- Single digit: an=1110, seg=0100100 held 10 cycles -> after edge 5, digits[3:0]=2 and digit_valid=0001; exactly one update pulse and no further pulses.
- Glitch rejection: an=1101, seg=0010000 for 3 cycles, then 1 cycle of 1011, then 1101/0010000 held -> no update until 4 stable samples; then digits[7:4]=9 and one update.
- Full scan: 1110:0, 1101:1, 1011:blank (1111111), 0111:7, each held 6 cycles -> digits=16'h7F10, digit_valid=1011, four updates, one frame_done coincident with the fourth update.
- Illegal inputs:
  - an=1100 held -> one bad_pattern, no update, outputs unchanged.
  - Then an=1110, seg=0000001 -> bad_pattern and update together, digit_valid[0]=0, digits[3:0] unchanged.
- Reset mid-settle: an=0111, seg=1111000 held; rst pulsed at cycle 2 -> no update before reset; first update 4 samples after reset release, with digits[15:12]=7.
